// File: rtl/axl_ps_master_if.sv
// ============================================================================
// Module   : axl_ps_master_if
// Brief    : Command/response port plus AXI-Lite master channels for axl_ps_master.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface axl_ps_master_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_we;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic [ADDR_WIDTH-1:0] waddr;
  logic                  wavalid;
  logic                  waready;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wvalid;
  logic                  wready;
  logic                  wresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] raddr;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic                  rready;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready,
    input  waready, wready, wresp, bvalid, arready, rdata, rvalid,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output waddr, wavalid, wdata, wvalid, bready, raddr, arvalid, rready
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready,
    output waready, wready, wresp, bvalid, arready, rdata, rvalid,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  waddr, wavalid, wdata, wvalid, bready, raddr, arvalid, rready
  );
endinterface

`default_nettype wire

// File: rtl/axl_ps_master.sv
// ============================================================================
// Module   : axl_ps_master
// Brief    : Single-outstanding AXI-Lite initiator driven by a valid/ready
//            command port; optional response timeout via AXL_MST_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module axl_ps_master #(
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic            clk,
  input  logic            rst,
  axl_ps_master_if.master io_bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_WRESP = 3'd2,
    ST_READ  = 3'd3,
    ST_RDATA = 3'd4,
    ST_RESP  = 3'd5
  } state_t;

  if (TIMEOUT_CYCLES < 2) begin : g_tmo_param_chk
    $error("axl_ps_master: TIMEOUT_CYCLES must be >= 2");
  end

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_err;
  logic                  r_aw_done;
  logic                  r_w_done;

  logic w_cmd_ready, w_wavalid, w_wvalid, w_bready;
  logic w_arvalid, w_rready, w_rsp_valid;
  logic w_cmd_hs, w_aw_hs, w_w_hs, w_b_hs, w_r_hs;
  logic w_busy, w_fin, w_tmo_hit, w_tmo;

  assign w_busy = (r_state == ST_WRITE) || (r_state == ST_WRESP) ||
                  (r_state == ST_READ)  || (r_state == ST_RDATA);

`ifdef AXL_MST_TIMEOUT_EN
  localparam int c_TMO_W = $clog2(TIMEOUT_CYCLES);

  logic [c_TMO_W-1:0] r_tmo_cnt;

  // Idle and RESP hold the counter at zero, so it starts clean on entry to WRITE/READ.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo_cnt <= '0;
    end else if (w_busy) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end else begin
      r_tmo_cnt <= '0;
    end
  end

  assign w_tmo_hit = w_busy && (r_tmo_cnt == c_TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cmd_ready = 1'b0;
    w_wavalid   = 1'b0;
    w_wvalid    = 1'b0;
    w_bready    = 1'b0;
    w_arvalid   = 1'b0;
    w_rready    = 1'b0;
    w_rsp_valid = 1'b0;
    w_fin       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cmd_ready = !rst;
        if (io_bus.cmd_valid && w_cmd_ready) begin
          w_state_nxt = io_bus.cmd_we ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE: begin
        w_wavalid = !r_aw_done;
        w_wvalid  = !r_w_done;
        // Each channel is finished if it completed earlier or completes now.
        w_fin = (r_aw_done || io_bus.waready) && (r_w_done || io_bus.wready);
        if (w_fin) w_state_nxt = ST_WRESP;
      end
      ST_WRESP: begin
        w_bready = 1'b1;
        w_fin    = io_bus.bvalid;
        if (w_fin) w_state_nxt = ST_RESP;
      end
      ST_READ: begin
        w_arvalid = 1'b1;
        w_fin     = io_bus.arready;
        if (w_fin) w_state_nxt = ST_RDATA;
      end
      ST_RDATA: begin
        w_rready = 1'b1;
        w_fin    = io_bus.rvalid;
        if (w_fin) w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        w_rsp_valid = 1'b1;
        if (io_bus.rsp_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_tmo = w_tmo_hit && !w_fin;
    if (w_tmo) w_state_nxt = ST_RESP;
  end

  assign w_cmd_hs = w_cmd_ready && io_bus.cmd_valid;
  assign w_aw_hs  = w_wavalid && io_bus.waready;
  assign w_w_hs   = w_wvalid && io_bus.wready;
  assign w_b_hs   = w_bready && io_bus.bvalid;
  assign w_r_hs   = w_rready && io_bus.rvalid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
    end else begin
      if (w_cmd_hs) begin
        r_addr    <= io_bus.cmd_addr;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
        if (io_bus.cmd_we) r_wdata <= io_bus.cmd_wdata;
      end
      if (w_aw_hs) r_aw_done <= 1'b1;
      if (w_w_hs)  r_w_done  <= 1'b1;
      if (w_b_hs) begin
        r_rsp_err   <= io_bus.wresp;
        r_rsp_rdata <= '0;
      end
      if (w_r_hs) begin
        r_rsp_rdata <= io_bus.rdata;
        r_rsp_err   <= 1'b0;
      end
      if (w_tmo) begin
        r_rsp_rdata <= '0;
        r_rsp_err   <= 1'b1;
      end
    end
  end

  assign io_bus.cmd_ready = w_cmd_ready;
  assign io_bus.rsp_valid = w_rsp_valid;
  assign io_bus.rsp_rdata = r_rsp_rdata;
  assign io_bus.rsp_err   = r_rsp_err;
  assign io_bus.waddr     = r_addr;
  assign io_bus.wavalid   = w_wavalid;
  assign io_bus.wdata     = r_wdata;
  assign io_bus.wvalid    = w_wvalid;
  assign io_bus.bready    = w_bready;
  assign io_bus.raddr     = r_addr;
  assign io_bus.arvalid   = w_arvalid;
  assign io_bus.rready    = w_rready;

endmodule

`default_nettype wire

// File: tb/tb_axl_ps_master.sv
// ============================================================================
// Module   : tb_axl_ps_master
// Brief    : Directed plus randomized bench for axl_ps_master with a
//            cycle-arithmetic timing model and a memory-backed slave.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_axl_ps_master;
  localparam int AW  = 4;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axl_ps_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axl_ps_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .io_bus(bus)
  );

  int n_chk = 0;
  int n_err = 0;
  logic [DW-1:0] smem    [16];
  logic [DW-1:0] mdl_mem [16];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_slave();
    bus.waready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.wresp = 1'b0;
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata  = '0;
  endtask

  task automatic chk_axi_quiet(input string tag);
    chk({tag, "_wavalid"}, bus.wavalid, 0);
    chk({tag, "_wvalid"},  bus.wvalid,  0);
    chk({tag, "_bready"},  bus.bready,  0);
    chk({tag, "_arvalid"}, bus.arvalid, 0);
    chk({tag, "_rready"},  bus.rready,  0);
  endtask

  // One command through to its response; timing is predicted from slave delays.
  task automatic run(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                     input int aw_d, input int w_d, input int b_d, input bit b_early,
                     input bit berr, input int ar_d, input int r_d, input bit tmo,
                     input int bp);
    int aw_hs, w_hs, mx, b_start, b_hs, ar_hs, r_hs, rr_end, rsp_c;
    logic [AW-1:0] cw_a;
    logic [DW-1:0] cw_d, e_rd;
    logic          e_err;
    aw_hs = 0; w_hs = 0; mx = 0; b_start = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
    cw_a = '0; cw_d = '0;
    if (we) begin
      aw_hs   = 1 + aw_d;
      w_hs    = 1 + w_d;
      mx      = (aw_hs > w_hs) ? aw_hs : w_hs;
      b_start = b_early ? 1 : mx + 1 + b_d;
      b_hs    = (b_start > mx + 1) ? b_start : mx + 1;
      rsp_c   = b_hs + 1;
      rr_end  = 0;
      e_rd    = '0;
      e_err   = berr;
      if (!berr) mdl_mem[addr] = data;
    end else begin
      ar_hs  = 1 + ar_d;
      r_hs   = ar_hs + 1 + r_d;
      rsp_c  = tmo ? 1 + TMO : r_hs + 1;
      rr_end = tmo ? rsp_c - 1 : r_hs;
      e_rd   = tmo ? '0 : mdl_mem[addr];
      e_err  = tmo;
    end

    bus.cmd_valid = 1'b1; bus.cmd_we = we; bus.cmd_addr = addr; bus.cmd_wdata = data;
    #1 chk("cmd_ready_idle", bus.cmd_ready, 1);
    @(posedge clk); @(negedge clk);
    bus.cmd_we = 1'($urandom); bus.cmd_addr = AW'($urandom); bus.cmd_wdata = $urandom;

    for (int k = 1; k < rsp_c; k++) begin
      if (we) begin
        bus.waready = (k >= aw_hs);
        bus.wready  = (k >= w_hs);
        bus.bvalid  = (k >= b_start) && (k <= b_hs);
        bus.wresp   = berr;
      end else begin
        bus.arready = (k >= ar_hs);
        bus.rvalid  = !tmo && (k == r_hs);
        bus.rdata   = (!tmo && k == r_hs) ? smem[bus.raddr] : $urandom;
      end
      #1;
      chk("cmd_ready_busy", bus.cmd_ready, 0);
      chk("rsp_valid_early", bus.rsp_valid, 0);
      if (we) begin
        chk("wavalid", bus.wavalid, (k <= aw_hs));
        chk("wvalid",  bus.wvalid,  (k <= w_hs));
        chk("bready",  bus.bready,  (k > mx) && (k <= b_hs));
        chk("arvalid_wr", bus.arvalid, 0);
        chk("rready_wr",  bus.rready,  0);
        if (k <= aw_hs) chk("waddr", bus.waddr, addr);
        if (k <= w_hs)  chk("wdata", bus.wdata, data);
        if (k == aw_hs) cw_a = bus.waddr;
        if (k == w_hs)  cw_d = bus.wdata;
        if (k == b_hs && !berr) smem[cw_a] = cw_d;
      end else begin
        chk("arvalid", bus.arvalid, (k <= ar_hs));
        chk("rready",  bus.rready,  (k > ar_hs) && (k <= rr_end));
        chk("wavalid_rd", bus.wavalid, 0);
        chk("wvalid_rd",  bus.wvalid,  0);
        chk("bready_rd",  bus.bready,  0);
        if (k <= ar_hs) chk("raddr", bus.raddr, addr);
      end
      @(posedge clk); @(negedge clk);
    end

    idle_slave();
    #1;
    chk("rsp_valid", bus.rsp_valid, 1);
    chk("rsp_rdata", bus.rsp_rdata, e_rd);
    chk("rsp_err",   bus.rsp_err,   e_err);
    chk("cmd_ready_resp", bus.cmd_ready, 0);
    chk_axi_quiet("resp");
    for (int j = 0; j < bp; j++) begin
      @(posedge clk); @(negedge clk); #1;
      chk("bp_rsp_valid", bus.rsp_valid, 1);
      chk("bp_rsp_rdata", bus.rsp_rdata, e_rd);
      chk("bp_rsp_err",   bus.rsp_err,   e_err);
      chk("bp_cmd_ready", bus.cmd_ready, 0);
    end
    bus.rsp_ready = 1'b1;
    bus.cmd_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    bus.rsp_ready = 1'b0;
    #1;
    chk("rsp_valid_done", bus.rsp_valid, 0);
    chk("cmd_ready_after", bus.cmd_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] v;
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_we = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    idle_slave();
    for (int i = 0; i < 16; i++) begin
      v = $urandom;
      smem[i] = v;
      mdl_mem[i] = v;
    end

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_waddr", bus.waddr, 0);
    chk("rst_raddr", bus.raddr, 0);
    chk("rst_wdata", bus.wdata, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk_axi_quiet("rst");
    rst = 1'b0;
    #1 chk("post_rst_cmd_ready", bus.cmd_ready, 1);
    @(negedge clk);

    // Zero-wait write, delayed AR read, late AW with error response.
    run(1'b1, 4'h4, 32'hDEADBEEF, 0, 0, 0, 1'b0, 1'b0, 0, 0, 1'b0, 0);
    smem[2] = 32'h12345678; mdl_mem[2] = 32'h12345678;
    run(1'b0, 4'h2, 32'h0, 0, 0, 0, 1'b0, 1'b0, 3, 0, 1'b0, 0);
    run(1'b1, 4'h9, 32'hCAFEF00D, 2, 0, 0, 1'b0, 1'b1, 0, 0, 1'b0, 0);
    run(1'b0, 4'h4, 32'h0, 0, 0, 0, 1'b0, 1'b0, 0, 0, 1'b0, 5);
    run(1'b1, 4'hA, 32'h0BADF00D, 0, 3, 1, 1'b1, 1'b0, 0, 0, 1'b0, 5);

    // Reset while waiting in WRESP abandons the write.
    bus.cmd_valid = 1'b1; bus.cmd_we = 1'b1; bus.cmd_addr = 4'h7; bus.cmd_wdata = 32'h55AA55AA;
    bus.waready = 1'b1; bus.wready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(posedge clk); @(negedge clk); #1;
    chk("mid_bready", bus.bready, 1);
    rst = 1'b1;
    @(posedge clk); @(negedge clk); #1;
    chk("mid_rst_cmd_ready", bus.cmd_ready, 0);
    chk("mid_rst_rsp_valid", bus.rsp_valid, 0);
    chk("mid_rst_waddr", bus.waddr, 0);
    chk("mid_rst_wdata", bus.wdata, 0);
    chk("mid_rst_rsp_err", bus.rsp_err, 0);
    chk_axi_quiet("mid_rst");
    rst = 1'b0;
    idle_slave();
    for (int j = 0; j < 2; j++) begin
      #1;
      chk("post_mid_rsp_valid", bus.rsp_valid, 0);
      chk("post_mid_cmd_ready", bus.cmd_ready, 1);
      @(negedge clk);
    end
    run(1'b0, 4'h9, 32'h0, 0, 0, 0, 1'b0, 1'b0, 1, 2, 1'b0, 0);

`ifdef AXL_MST_TIMEOUT_EN
    run(1'b0, 4'h5, 32'h0, 0, 0, 0, 1'b0, 1'b0, 0, 0, 1'b1, 2);
`endif

    for (int t = 0; t < 24; t++) begin
      run(1'($urandom), AW'($urandom), $urandom,
          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
          $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/axl_ps_master.md
Name: axl_ps_master

Overview:
- AXI-Lite initiator: accepts single-beat read/write commands on a valid/ready command port and drives the AXI-Lite master channels.
- Returns read data and error status on a valid/ready response port.
- Counterpart to the AXI-Lite responder path: lets PL nodes issue register accesses to AXI-Lite slaves, and lets benches drive the existing slave adapter.
- Strictly one outstanding transaction.

Parameters:
- ADDR_WIDTH, 4, width of waddr/raddr/cmd_addr
- DATA_WIDTH, 32, width of wdata/rdata/cmd_wdata/rsp_rdata
- TIMEOUT_CYCLES, 256, response timeout in cycles; used only with AXL_MST_TIMEOUT_EN; must be >= 2

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_we  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  target address
- cmd_wdata  in  DATA_WIDTH  write data; ignored for reads
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
- rsp_err  out  1  1 = slave error (wresp) or timeout
- waddr  out  ADDR_WIDTH  AW address
- wavalid  out  1  AW valid
- waready  in  1  AW ready
- wdata  out  DATA_WIDTH  W data
- wvalid  out  1  W valid
- wready  in  1  W ready
- wresp  in  1  B response; 1 = error
- bvalid  in  1  B valid
- bready  out  1  B ready
- raddr  out  ADDR_WIDTH  AR address
- arvalid  out  1  AR valid
- arready  in  1  AR ready
- rdata  in  DATA_WIDTH  R data
- rvalid  in  1  R valid
- rready  out  1  R ready

Behaviour:
- Reset: applied when rst = 1 at a clk edge. Outputs during and after reset:
  - all valid/ready outputs 0
  - waddr, raddr, wdata, rsp_rdata, rsp_err = 0
  - FSM to IDLE; timeout counter 0
- Reset mid-transaction abandons the transaction; no response is produced.
- FSM states: IDLE, WRITE, WRESP, READ, RDATA, RESP.
- IDLE:
  - cmd_ready = 1.
  - On handshake, register addr/data/we.
  - Write: go to WRITE with wavalid = 1 and wvalid = 1 from the next cycle.
  - Read: go to READ with arvalid = 1 from the next cycle.
- WRITE:
  - wavalid drops the cycle after the AW handshake; wvalid drops the cycle after the W handshake.
  - The two channels complete independently, in either order or in the same cycle.
  - When both are done, go to WRESP.
  - waddr/wdata stay stable while their valid is high.
- WRESP:
  - bready = 1.
  - On bvalid: capture rsp_err = wresp, rsp_rdata = 0, go to RESP.
  - bvalid arriving early (before AW/W complete) is not accepted; bready stays 0 outside WRESP.
- READ:
  - arvalid held with raddr stable until arready; then go to RDATA.
- RDATA:
  - rready = 1.
  - On rvalid: capture rsp_rdata = rdata, rsp_err = 0, go to RESP.
- RESP:
  - rsp_valid = 1 with data/err stable until rsp_ready.
  - On handshake go to IDLE.
  - cmd_ready = 0 in every state except IDLE.
- Latency, zero-wait slave:
  - Write: cmd handshake at cycle 0; AW/W handshake at cycle 1; B at cycle 2; rsp_valid at cycle 3.
  - Read: same timing with AR at cycle 1 and R at cycle 2.
- Throughput: at most one command per 4 cycles.
- Valid outputs never drop before their handshake (AXI rule).

Optional Feature:
- Macro: AXL_MST_TIMEOUT_EN.
- Enabled:
  - Counter clears on entry to WRITE/READ and increments each cycle in WRITE, WRESP, READ and RDATA.
  - When it reaches TIMEOUT_CYCLES-1 with no completing handshake, all AXI valid/ready outputs drop to 0 and the FSM goes to RESP with rsp_err = 1, rsp_rdata = 0.
  - A completing handshake in the same cycle as expiry wins; no timeout is flagged.
- Disabled: no counter logic; the FSM waits indefinitely.

Test Plan:
- Write, zero-wait slave: cmd we = 1, addr 0x4, data 0xDEADBEEF -> waddr = 0x4 and wdata = 0xDEADBEEF at cycle 1; rsp_valid at cycle 3 with rsp_err = 0, rsp_rdata = 0.
- Read, arready delayed 3 cycles, rvalid with rdata 0x12345678 -> arvalid held 4 cycles with raddr stable; rsp_rdata = 0x12345678, rsp_err = 0.
- Write with waready late by 2 cycles and wready immediate, then wresp = 1 -> wvalid drops after cycle 1, wavalid held to cycle 3; rsp_err = 1.
- Back-pressure: rsp_ready = 0 for 5 cycles, with cmd_valid held high -> rsp_valid and data stable; cmd_ready stays 0; next command accepted only after the rsp handshake.
- Reset mid-transaction: rst = 1 while in WRESP -> next cycle all outputs 0, no rsp_valid; a subsequent read completes normally.
- AXL_MST_TIMEOUT_EN, TIMEOUT_CYCLES = 16, slave never asserts rvalid -> rready drops; rsp_valid with rsp_err = 1, rsp_rdata = 0, 16 cycles after entering READ.
